bennett_phase_monitor: RTL and testbench

Receive-side checker for the Bennett adiabatic clock generator (`bennett_clock`). It samples the `clkpos`/`clkneg` phase rails and `instFlag`, and tracks each charge → plateau → discharge cycle. It emits a one-cycle capture strobe when every rail is fully charged, plus a completion strobe and an instruction count. Any rail-sequencing violation is latched as a sticky error code. It sits beside the ALU datapath and replaces the ad-hoc "all rails high" detection used to drive the slow output-latch clocks.

---
 rtl/bennett_phase_monitor_if.sv | 17 +
 rtl/bennett_phase_monitor.sv | 200 ++++++++++++++++++++
 tb/tb_bennett_phase_monitor.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/bennett_phase_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : bennett_phase_monitor_if
// Brief    : Phase-rail bundle from the Bennett clock generator to its monitor.
// Revision : 1.0 - initial release
// ============================================================================
interface bennett_phase_monitor_if #(
  parameter int WIDTH = 13
);
  logic [WIDTH-1:0] clkpos;
  logic [WIDTH-1:0] clkneg;
  logic             instFlag;

  modport master (output clkpos, output clkneg, output instFlag);
  modport slave  (input  clkpos, input  clkneg, input  instFlag);
endinterface
`default_nettype wire

// File: rtl/bennett_phase_monitor.sv
`default_nettype none
// ============================================================================
// Module   : bennett_phase_monitor
// Brief    : Tracks charge/plateau/discharge of the Bennett phase rails, emits
//            capture/done strobes and latches the first sequencing error.
//            Optional stall timeout: define BENNETT_MON_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bennett_phase_monitor #(
  parameter  int WIDTH   = 13,
  parameter  int TIMEOUT = 64,
  localparam int LW      = $clog2(WIDTH + 1)
) (
  input  wire logic              clk,
  input  wire logic              reset,
  bennett_phase_monitor_if.slave rails,
  input  wire logic              clear_err,
  output logic [2:0]             phase,
  output logic [LW-1:0]          level,
  output logic                   capture_pulse,
  output logic                   done_pulse,
  output logic                   err,
  output logic [2:0]             err_code,
  output logic [15:0]            instr_count
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHARGE    = 3'd1,
    ST_PLATEAU   = 3'd2,
    ST_DISCHARGE = 3'd3,
    ST_ERROR     = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);
  localparam logic [LW:0]      C_STEP    = (LW + 1)'(1);
  localparam logic [LW-1:0]    C_FULL    = LW'(WIDTH);
  localparam logic [LW-1:0]    C_FULL_M1 = LW'(WIDTH - 1);

  state_t         state_q, state_d;
  logic [LW-1:0]  level_q, level_d;
  logic           armed_q, armed_d;
  logic           synced_q, synced_d;
  logic           capture_q, capture_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [2:0]     err_code_q, err_code_d;
  logic [15:0]    instr_count_q, instr_count_d;

  logic [LW-1:0]  w_lvl;
  logic           w_comp_ok, w_therm_ok, w_valid;
  logic           w_same, w_up, w_down;
  logic           w_timeout;
  logic [2:0]     w_code;

  assign w_comp_ok  = (rails.clkneg == ~rails.clkpos);
  // A thermometer code has no set bit above a clear one: x & (x+1) == 0.
  assign w_therm_ok = ((rails.clkpos & (rails.clkpos + C_ONE)) == '0);
  assign w_valid    = w_comp_ok && w_therm_ok;

  always_comb begin
    w_lvl = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_lvl = w_lvl + LW'(rails.clkpos[i]);
    end
  end

  assign w_same = (w_lvl == level_q);
  assign w_up   = ({1'b0, w_lvl} == {1'b0, level_q} + C_STEP);
  assign w_down = ({1'b0, w_lvl} + C_STEP == {1'b0, level_q});

`ifdef BENNETT_MON_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_q, stall_d;
  logic          w_timed;

  assign w_timed = (state_q == ST_CHARGE) || (state_q == ST_DISCHARGE);

  always_comb begin
    stall_d   = '0;
    w_timeout = 1'b0;
    if (synced_q && w_timed && w_valid && w_same) begin
      stall_d   = stall_q + SW'(1);
      w_timeout = (int'(stall_q) + 1 >= TIMEOUT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Lowest code wins when several faults show up in one sample.
  always_comb begin
    w_code = 3'd0;
    if (!w_comp_ok)                                                 w_code = 3'd1;
    else if (!w_therm_ok)                                           w_code = 3'd2;
    else if (!(w_same || w_up || w_down))                           w_code = 3'd3;
    else if ((state_q == ST_CHARGE && w_down) ||
             (state_q == ST_DISCHARGE && w_up))                     w_code = 3'd4;
    else if (state_q == ST_IDLE && w_up && !(armed_q || rails.instFlag)) w_code = 3'd5;
    else if (w_timeout)                                             w_code = 3'd6;
    else if (rails.instFlag && state_q != ST_IDLE)                  w_code = 3'd7;
  end

  always_comb begin
    state_d       = state_q;
    level_d       = level_q;
    armed_d       = armed_q;
    synced_d      = synced_q;
    capture_d     = 1'b0;
    done_d        = 1'b0;
    err_d         = err_q;
    err_code_d    = err_code_q;
    instr_count_d = instr_count_q;

    if (!synced_q) begin
      if (w_valid && w_lvl == '0) synced_d = 1'b1;
    end else if (state_q == ST_ERROR) begin
      if (clear_err && w_valid && w_lvl == '0) begin
        state_d    = ST_IDLE;
        level_d    = '0;
        armed_d    = 1'b0;
        err_d      = 1'b0;
        err_code_d = 3'd0;
      end
    end else if (w_code != 3'd0) begin
      state_d    = ST_ERROR;
      armed_d    = 1'b0;
      err_d      = 1'b0 | 1'b1;
      err_code_d = w_code;
    end else begin
      level_d = w_lvl;
      case (state_q)
        ST_IDLE: begin
          if (w_up) begin
            state_d = ST_CHARGE;
            armed_d = 1'b0;
          end else begin
            armed_d = armed_q || rails.instFlag;
          end
        end
        ST_CHARGE: begin
          if (w_lvl == C_FULL) begin
            state_d   = ST_PLATEAU;
            capture_d = 1'b1;
          end
        end
        ST_PLATEAU: begin
          if (w_lvl == C_FULL_M1) state_d = ST_DISCHARGE;
        end
        ST_DISCHARGE: begin
          if (w_lvl == '0) begin
            state_d       = ST_IDLE;
            done_d        = 1'b1;
            instr_count_d = instr_count_q + 16'd1;
          end
        end
        default: state_d = ST_ERROR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      level_q       <= '0;
      armed_q       <= 1'b0;
      synced_q      <= 1'b0;
      capture_q     <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= 3'd0;
      instr_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      armed_q       <= armed_d;
      synced_q      <= synced_d;
      capture_q     <= capture_d;
      done_q        <= done_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign phase         = state_q;
  assign level         = level_q;
  assign capture_pulse = capture_q;
  assign done_pulse    = done_q;
  assign err           = err_q;
  assign err_code      = err_code_q;
  assign instr_count   = instr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_bennett_phase_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_bennett_phase_monitor
// Brief    : Directed self-checking bench for bennett_phase_monitor (WIDTH=13).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bennett_phase_monitor;

  localparam int WIDTH = 13;
  localparam int LW    = $clog2(WIDTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          clear_err;
  logic [2:0]    phase;
  logic [LW-1:0] level;
  logic          capture_pulse;
  logic          done_pulse;
  logic          err;
  logic [2:0]    err_code;
  logic [15:0]   instr_count;

  int n_checks = 0;
  int n_err    = 0;
  int cap_cnt  = 0;
  int done_cnt = 0;

  bennett_phase_monitor_if #(.WIDTH(WIDTH)) bus ();

  bennett_phase_monitor #(.WIDTH(WIDTH), .TIMEOUT(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .rails         (bus.slave),
    .clear_err     (clear_err),
    .phase         (phase),
    .level         (level),
    .capture_pulse (capture_pulse),
    .done_pulse    (done_pulse),
    .err           (err),
    .err_code      (err_code),
    .instr_count   (instr_count)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] therm(input int k);
    logic [WIDTH:0] t;
    t = (WIDTH + 1)'(1) << k;
    t = t - (WIDTH + 1)'(1);
    return t[WIDTH-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive raw rails for one sample, then observe just after the edge.
  task automatic raw(input logic [WIDTH-1:0] pos, input logic [WIDTH-1:0] neg, input logic flag);
    bus.clkpos   = pos;
    bus.clkneg   = neg;
    bus.instFlag = flag;
    @(posedge clk);
    #1;
    if (capture_pulse) cap_cnt++;
    if (done_pulse)    done_cnt++;
    bus.instFlag = 1'b0;
  endtask

  task automatic step(input int k, input logic flag);
    raw(therm(k), ~therm(k), flag);
  endtask

  task automatic ramp_up(input int from, input int to);
    for (int k = from; k <= to; k++) step(k, 1'b0);
  endtask

  task automatic ramp_down(input int from, input int to);
    for (int k = from; k >= to; k--) step(k, 1'b0);
  endtask

  task automatic recover(input string tag);
    clear_err = 1'b1;
    step(0, 1'b0);
    clear_err = 1'b0;
    chk({tag, "_clr_phase"}, 32'(phase), 32'd0);
    chk({tag, "_clr_err"},   32'(err),   32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    clear_err    = 1'b0;
    bus.clkpos   = '0;
    bus.clkneg   = '1;
    bus.instFlag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_phase",   32'(phase),         32'd0);
    chk("rst_level",   32'(level),         32'd0);
    chk("rst_capture", 32'(capture_pulse), 32'd0);
    chk("rst_done",    32'(done_pulse),    32'd0);
    chk("rst_err",     32'(err),           32'd0);
    chk("rst_code",    32'(err_code),      32'd0);
    chk("rst_count",   32'(instr_count),   32'd0);
    reset = 1'b0;

    // Nominal cycle: sync, arm, full ramp with a 3-sample extra plateau.
    step(0, 1'b0);
    step(0, 1'b1);
    step(1, 1'b0);
    chk("chg_phase", 32'(phase), 32'd1);
    chk("chg_level", 32'(level), 32'd1);
    ramp_up(2, 12);
    chk("pre_cap", 32'(capture_pulse), 32'd0);
    step(13, 1'b0);
    chk("cap_pulse", 32'(capture_pulse), 32'd1);
    chk("plat_phase", 32'(phase), 32'd2);
    chk("plat_level", 32'(level), 32'd13);
    repeat (3) step(13, 1'b0);
    chk("cap_one_wide", 32'(capture_pulse), 32'd0);
    step(12, 1'b0);
    chk("dis_phase", 32'(phase), 32'd3);
    ramp_down(11, 1);
    chk("pre_done", 32'(done_pulse), 32'd0);
    step(0, 1'b0);
    chk("done_pulse", 32'(done_pulse), 32'd1);
    chk("idle_phase", 32'(phase), 32'd0);
    chk("count_1", 32'(instr_count), 32'd1);
    step(0, 1'b0);
    chk("done_one_wide", 32'(done_pulse), 32'd0);
    chk("nom_err", 32'(err), 32'd0);
    chk("cap_total", 32'(cap_cnt), 32'd1);
    chk("done_total", 32'(done_cnt), 32'd1);

    // Charge without arming.
    step(1, 1'b0);
    chk("unarmed_err", 32'(err), 32'd1);
    chk("unarmed_code", 32'(err_code), 32'd5);
    chk("unarmed_phase", 32'(phase), 32'd4);
    recover("unarmed");
    chk("unarmed_clr_code", 32'(err_code), 32'd0);

    // Level jump 4 -> 6.
    step(0, 1'b1);
    ramp_up(1, 4);
    step(6, 1'b0);
    chk("jump_code", 32'(err_code), 32'd3);
    chk("jump_level_frozen", 32'(level), 32'd4);
    recover("jump");

    // Non-thermometer rails.
    step(0, 1'b1);
    ramp_up(1, 2);
    raw(13'h0005, ~13'h0005, 1'b0);
    chk("therm_code", 32'(err_code), 32'd2);
    recover("therm");

    // Complement mismatch on bit 0 only.
    step(0, 1'b1);
    ramp_up(1, 2);
    raw(13'h0007, ~13'h0007 | 13'h0001, 1'b0);
    chk("comp_code", 32'(err_code), 32'd1);
    recover("comp");

    // Reversal in discharge, then a jump that must not overwrite the code.
    step(0, 1'b1);
    ramp_up(1, 13);
    ramp_down(12, 8);
    step(9, 1'b0);
    chk("rev_code", 32'(err_code), 32'd4);
    chk("rev_phase", 32'(phase), 32'd4);
    step(12, 1'b0);
    chk("rev_sticky_code", 32'(err_code), 32'd4);
    recover("rev");

    // instFlag outside IDLE.
    step(0, 1'b1);
    step(1, 1'b0);
    step(2, 1'b1);
    chk("flag_code", 32'(err_code), 32'd7);
    recover("flag");

    // Reset at level 7 mid-charge: rest of that ramp is ignored, not counted.
    cap_cnt  = 0;
    done_cnt = 0;
    step(0, 1'b1);
    ramp_up(1, 6);
    reset = 1'b1;
    step(7, 1'b0);
    reset = 1'b0;
    chk("midrst_phase", 32'(phase), 32'd0);
    chk("midrst_count", 32'(instr_count), 32'd0);
    ramp_up(8, 13);
    ramp_down(12, 0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_no_strobes", 32'(cap_cnt + done_cnt), 32'd0);
    step(0, 1'b1);
    ramp_up(1, 13);
    ramp_down(12, 0);
    chk("midrst_next_count", 32'(instr_count), 32'd1);
    chk("midrst_next_err", 32'(err), 32'd0);

    // Hold level 5 in CHARGE for 64 further samples.
    step(0, 1'b1);
    ramp_up(1, 5);
    repeat (64) step(5, 1'b0);
`ifdef BENNETT_MON_TIMEOUT_EN
    chk("timeout_code", 32'(err_code), 32'd6);
`else
    chk("hold_err", 32'(err), 32'd0);
    chk("hold_phase", 32'(phase), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
